// File: rtl/video_sync_pkg.sv
// Shared types and default raster timing for the video sync generator.
// Timing is described per axis as active/front-porch/sync/back-porch.
package video_sync_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } axis_timing_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sync_state_t;

    localparam axis_timing_t H_TIMING_DEFAULT = '{
        active: 16'd320, fp: 16'd8, sync: 16'd32, bp: 16'd24
    };
    localparam axis_timing_t V_TIMING_DEFAULT = '{
        active: 16'd240, fp: 16'd4, sync: 16'd4, bp: 16'd14
    };

    function automatic int unsigned total(input axis_timing_t t);
        return 32'(t.active) + 32'(t.fp) + 32'(t.sync) + 32'(t.bp);
    endfunction

endpackage

// File: rtl/video_sync_gen_axis_counter.sv
// One raster axis: wrapping position counter plus the blank/sync decode of
// the position it is about to take, so the parent can register flags in step.
module sync_axis_counter #(
    parameter int CW         = 10,
    parameter int LAST       = 383,
    parameter int ACTIVE     = 320,
    parameter int SYNC_START = 328,
    parameter int SYNC_END   = 360
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic          last,
    output logic          blank,
    output logic          blank_nxt,
    output logic          sync_nxt
);

    localparam logic [CW-1:0] LAST_C       = CW'(LAST);
    localparam logic [CW-1:0] ACTIVE_C     = CW'(ACTIVE);
    localparam logic [CW-1:0] SYNC_START_C = CW'(SYNC_START);
    localparam logic [CW-1:0] SYNC_END_C   = CW'(SYNC_END);
    localparam logic [CW-1:0] ONE_C        = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic          blank_q;

    assign count = count_q;
    assign last  = (count_q == LAST_C);
    assign blank = blank_q;

    // Next position and the blank/sync decode of that next position
    always_comb begin
        count_d = count_q;
        if (step) begin
            if (last) begin
                count_d = '0;
            end else begin
                count_d = count_q + ONE_C;
            end
        end else begin
            count_d = count_q;
        end
        blank_nxt = (count_d >= ACTIVE_C);
        sync_nxt  = (count_d >= SYNC_START_C) && (count_d < SYNC_END_C);
    end

    // Position and blank registers; reset parks on the last position
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= LAST_C;
            blank_q <= 1'b1;
        end else begin
            count_q <= count_d;
            blank_q <= blank_nxt;
        end
    end

endmodule

// File: rtl/video_sync_gen.sv
// Programmable raster timing generator: run/stop FSM, H/V axis counters and
// registered sync/blank/de/pulse outputs, all aligned to the same position.
module video_sync_gen
    import video_sync_pkg::*;
#(
    parameter int H_ACTIVE = int'(H_TIMING_DEFAULT.active),
    parameter int H_FP     = int'(H_TIMING_DEFAULT.fp),
    parameter int H_SYNC   = int'(H_TIMING_DEFAULT.sync),
    parameter int H_BP     = int'(H_TIMING_DEFAULT.bp),
    parameter int V_ACTIVE = int'(V_TIMING_DEFAULT.active),
    parameter int V_FP     = int'(V_TIMING_DEFAULT.fp),
    parameter int V_SYNC   = int'(V_TIMING_DEFAULT.sync),
    parameter int V_BP     = int'(V_TIMING_DEFAULT.bp),
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic          run,
    input  logic          hs_invert,
    input  logic          vs_invert,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          busy
);

    localparam axis_timing_t H_T = '{
        active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)
    };
    localparam axis_timing_t V_T = '{
        active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)
    };
    localparam int H_TOTAL = int'(total(H_T));
    localparam int V_TOTAL = int'(total(V_T));

    if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_timing
        $fatal(1, "video_sync_gen: illegal raster timing parameters");
    end

    sync_state_t state_q, state_d;
    logic hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
    logic hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic line_start_q, line_start_d, frame_start_q, frame_start_d;
    logic busy_q, busy_d;

    logic h_last_s, v_last_s, frame_end_s, h_step_s, v_step_s;
    logic h_blank_nxt_s, v_blank_nxt_s, h_sync_nxt_s, v_sync_nxt_s;

    // IDLE always sits on the frame end, so one rule covers start, run and stop
    assign frame_end_s = h_last_s & v_last_s;
    assign h_step_s    = ce_pix & (run | ~frame_end_s);
    assign v_step_s    = h_step_s & h_last_s;

    sync_axis_counter #(
        .CW(CW), .LAST(H_TOTAL - 1), .ACTIVE(H_ACTIVE),
        .SYNC_START(H_ACTIVE + H_FP), .SYNC_END(H_ACTIVE + H_FP + H_SYNC)
    ) u_h_axis (
        .clk(clk), .reset_n(reset_n), .step(h_step_s), .count(hcount),
        .last(h_last_s), .blank(hblank), .blank_nxt(h_blank_nxt_s), .sync_nxt(h_sync_nxt_s)
    );

    sync_axis_counter #(
        .CW(CW), .LAST(V_TOTAL - 1), .ACTIVE(V_ACTIVE),
        .SYNC_START(V_ACTIVE + V_FP), .SYNC_END(V_ACTIVE + V_FP + V_SYNC)
    ) u_v_axis (
        .clk(clk), .reset_n(reset_n), .step(v_step_s), .count(vcount),
        .last(v_last_s), .blank(vblank), .blank_nxt(v_blank_nxt_s), .sync_nxt(v_sync_nxt_s)
    );

    // Run/stop FSM, polarity latch at frame start, and next output values
    always_comb begin
        state_d       = state_q;
        hs_pol_d      = hs_pol_q;
        vs_pol_d      = vs_pol_q;
        line_start_d  = h_step_s & h_last_s;
        frame_start_d = h_step_s & frame_end_s;
        if (ce_pix && frame_end_s) begin
            state_d = run ? RUN : IDLE;
        end else begin
            state_d = state_q;
        end
        if (frame_start_d) begin
            hs_pol_d = HS_POL ^ hs_invert;
            vs_pol_d = VS_POL ^ vs_invert;
        end else begin
            hs_pol_d = hs_pol_q;
            vs_pol_d = vs_pol_q;
        end
        busy_d  = (state_d == RUN);
        hsync_d = h_sync_nxt_s ? hs_pol_d : ~hs_pol_d;
        vsync_d = v_sync_nxt_s ? vs_pol_d : ~vs_pol_d;
        de_d    = ~h_blank_nxt_s & ~v_blank_nxt_s;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            hs_pol_q      <= HS_POL;
            vs_pol_q      <= VS_POL;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_pol_q      <= hs_pol_d;
            vs_pol_q      <= vs_pol_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            busy_q        <= busy_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_video_sync_gen.sv
// Directed bench: a reduced-timing instance (15x8 raster) exercises frame-level
// behaviour; a default-timing instance checks reset values and one full line.
module tb_video_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, ce, run, hs_inv, vs_inv;
    logic ce_b, run_b, inv_b;

    logic [3:0] hcount, vcount;
    logic hsync, vsync, hblank, vblank, de, ls, fs, busy;
    logic [9:0] hc_b, vc_b;
    logic hs_b, vs_b, hbl_b, vbl_b, de_b, ls_b, fs_b, busy_b;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model of the small raster (H total 15, V total 8)
    int   m_h, m_v;
    logic m_busy, m_hp, m_vp;

    video_sync_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce), .run(run),
        .hs_invert(hs_inv), .vs_invert(vs_inv),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .de(de),
        .line_start(ls), .frame_start(fs), .busy(busy)
    );

    video_sync_gen dut_big (
        .clk(clk), .reset_n(reset_n), .ce_pix(ce_b), .run(run_b),
        .hs_invert(inv_b), .vs_invert(inv_b),
        .hcount(hc_b), .vcount(vc_b), .hsync(hs_b), .vsync(vs_b),
        .hblank(hbl_b), .vblank(vbl_b), .de(de_b),
        .line_start(ls_b), .frame_start(fs_b), .busy(busy_b)
    );

    function automatic logic exp_hs(input int h, input logic p);
        return (h >= 10 && h <= 12) ? p : ~p;
    endfunction

    function automatic logic exp_vs(input int v, input logic p);
        return (v >= 5 && v <= 6) ? p : ~p;
    endfunction

    task automatic model_reset();
        m_h = 14; m_v = 7; m_busy = 1'b0; m_hp = 1'b0; m_vp = 1'b0;
    endtask

    // One clock edge; the model advances with the inputs seen at that edge
    task automatic tick();
        @(posedge clk);
        if (reset_n && ce) begin
            if (!m_busy) begin
                if (run) begin
                    m_busy = 1'b1; m_h = 0; m_v = 0; m_hp = hs_inv; m_vp = vs_inv;
                end
            end else if (m_h != 14) begin
                m_h++;
            end else if (m_v != 7) begin
                m_h = 0; m_v++;
            end else if (run) begin
                m_h = 0; m_v = 0; m_hp = hs_inv; m_vp = vs_inv;
            end else begin
                m_busy = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; run = 1'b0; ce = 1'b1; hs_inv = 1'b0; vs_inv = 1'b0;
        run_b = 1'b0; ce_b = 1'b1; inv_b = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests_run++; if (hcount !== 4'd14 || busy !== 1'b0) begin tests_failed++;
            $display("FAIL reset_held: got h=%0d busy=%0d expected h=14 busy=0", hcount, busy); end
        reset_n = 1'b1;
        repeat (6) tick();
        tests_run++; if (hcount !== 4'd14 || vcount !== 4'd7) begin tests_failed++;
            $display("FAIL reset_pos: got (%0d,%0d) expected (14,7)", hcount, vcount); end
        tests_run++; if (hsync !== 1'b1 || vsync !== 1'b1) begin tests_failed++;
            $display("FAIL reset_sync: got hs=%0d vs=%0d expected 1 1", hsync, vsync); end
        tests_run++; if ({de, busy, ls, fs} !== 4'b0000 || {hblank, vblank} !== 2'b11) begin tests_failed++;
            $display("FAIL reset_flags: got de/busy/ls/fs=%b blanks=%b expected 0000 11",
                     {de, busy, ls, fs}, {hblank, vblank}); end
        tests_run++; if (hc_b !== 10'd383 || vc_b !== 10'd261) begin tests_failed++;
            $display("FAIL reset_big_pos: got (%0d,%0d) expected (383,261)", hc_b, vc_b); end
        tests_run++; if ({hs_b, vs_b, de_b, busy_b} !== 4'b1100) begin tests_failed++;
            $display("FAIL reset_big_flags: got hs/vs/de/busy=%b expected 1100", {hs_b, vs_b, de_b, busy_b}); end
    endtask

    task automatic test_big_line();
        run_b = 1'b1;
        for (int k = 0; k <= 384; k++) begin
            tick();
            tests_run++; if (hc_b !== 10'(k % 384) || vc_b !== 10'(k / 384)) begin tests_failed++;
                $display("FAIL big_pos k=%0d: got (%0d,%0d) expected (%0d,%0d)", k, hc_b, vc_b, k % 384, k / 384); end
            tests_run++; if (de_b !== ((k % 384) < 320)) begin tests_failed++;
                $display("FAIL big_de k=%0d: got %0d expected %0d", k, de_b, ((k % 384) < 320)); end
            tests_run++; if (hs_b !== !((k % 384) >= 328 && (k % 384) < 360)) begin tests_failed++;
                $display("FAIL big_hsync k=%0d: got %0d", k, hs_b); end
            tests_run++; if (ls_b !== ((k % 384) == 0) || fs_b !== (k == 0)) begin tests_failed++;
                $display("FAIL big_pulses k=%0d: got ls=%0d fs=%0d", k, ls_b, fs_b); end
            tests_run++; if (busy_b !== 1'b1 || vs_b !== 1'b1) begin tests_failed++;
                $display("FAIL big_busy_vs k=%0d: got busy=%0d vs=%0d expected 1 1", k, busy_b, vs_b); end
        end
        run_b = 1'b0; ce_b = 1'b0;
    endtask

    task automatic test_frame();
        logic prev_vs;
        run = 1'b1;
        prev_vs = vsync;
        for (int t = 0; t <= 240; t++) begin
            tick();
            tests_run++; if (hcount !== 4'(t % 15) || vcount !== 4'((t / 15) % 8)) begin tests_failed++;
                $display("FAIL frame_pos t=%0d: got (%0d,%0d) expected (%0d,%0d)",
                         t, hcount, vcount, t % 15, (t / 15) % 8); end
            tests_run++; if (hsync !== exp_hs(t % 15, 1'b0) || vsync !== exp_vs((t / 15) % 8, 1'b0)) begin
                tests_failed++; $display("FAIL frame_sync t=%0d: got hs=%0d vs=%0d", t, hsync, vsync); end
            tests_run++; if (de !== ((t % 15) < 8 && ((t / 15) % 8) < 4) ||
                             hblank !== ((t % 15) >= 8) || vblank !== (((t / 15) % 8) >= 4)) begin
                tests_failed++; $display("FAIL frame_blank t=%0d: got de=%0d hb=%0d vb=%0d", t, de, hblank, vblank); end
            tests_run++; if (ls !== ((t % 15) == 0) || fs !== ((t % 120) == 0) || busy !== 1'b1) begin
                tests_failed++; $display("FAIL frame_pulses t=%0d: got ls=%0d fs=%0d busy=%0d", t, ls, fs, busy); end
            tests_run++; if (vsync !== prev_vs && hcount !== 4'd0) begin tests_failed++;
                $display("FAIL vsync_align t=%0d: vsync changed at hcount=%0d expected 0", t, hcount); end
            prev_vs = vsync;
        end
    endtask

    task automatic test_ce_div();
        logic [3:0] ph, pv;
        logic phs, pde;
        int last_ls = -1;
        int n_ls = 0;
        for (int c = 0; c < 120; c++) begin
            ce = ((c % 4) == 0);
            ph = hcount; pv = vcount; phs = hsync; pde = de;
            tick();
            if (ce) begin
                tests_run++; if (hcount !== m_h[3:0] || hsync !== exp_hs(m_h, 1'b0)) begin tests_failed++;
                    $display("FAIL cediv_step c=%0d: got h=%0d hs=%0d expected h=%0d", c, hcount, hsync, m_h); end
            end else begin
                tests_run++; if (hcount !== ph || vcount !== pv || hsync !== phs || de !== pde ||
                                 ls !== 1'b0 || fs !== 1'b0) begin tests_failed++;
                    $display("FAIL cediv_hold c=%0d: got h=%0d ls=%0d fs=%0d expected h=%0d pulses 0",
                             c, hcount, ls, fs, ph); end
            end
            if (ls === 1'b1) begin
                n_ls++;
                if (last_ls >= 0) begin
                    tests_run++; if (c - last_ls != 60) begin tests_failed++;
                        $display("FAIL cediv_period: got %0d clks expected 60", c - last_ls); end
                end
                last_ls = c;
            end
        end
        tests_run++; if (n_ls != 2) begin tests_failed++;
            $display("FAIL cediv_count: got %0d line_start pulses expected 2", n_ls); end
        ce = 1'b1;
    endtask

    task automatic test_polarity();
        int i;
        for (i = 0; i < 300 && vcount !== 4'd2; i++) tick();
        tests_run++; if (vcount !== 4'd2) begin tests_failed++;
            $display("FAIL pol_wait: got vcount=%0d expected 2", vcount); end
        hs_inv = 1'b1; vs_inv = 1'b1;
        for (i = 0; i < 200; i++) begin
            tick();
            if (fs === 1'b1) break;
            tests_run++; if (hsync !== exp_hs(m_h, 1'b0) || vsync !== exp_vs(m_v, 1'b0)) begin tests_failed++;
                $display("FAIL pol_early (%0d,%0d): got hs=%0d vs=%0d before frame_start", m_h, m_v, hsync, vsync); end
        end
        tests_run++; if (fs !== 1'b1) begin tests_failed++;
            $display("FAIL pol_fs_timeout: got fs=%0d expected 1", fs); end
        for (i = 0; i < 120; i++) begin
            tests_run++; if (hcount !== m_h[3:0] || hsync !== exp_hs(m_h, 1'b1) || vsync !== exp_vs(m_v, 1'b1)) begin
                tests_failed++; $display("FAIL pol_inverted (%0d,%0d): got h=%0d hs=%0d vs=%0d",
                                         m_h, m_v, hcount, hsync, vsync); end
            tick();
        end
        hs_inv = 1'b0; vs_inv = 1'b0;
        for (i = 0; i < 200; i++) begin
            tick();
            if (fs === 1'b1) break;
        end
        tests_run++; if (fs !== 1'b1 || hsync !== 1'b1 || vsync !== 1'b1) begin tests_failed++;
            $display("FAIL pol_restore: got fs=%0d hs=%0d vs=%0d expected 1 1 1", fs, hsync, vsync); end
    endtask

    task automatic test_stop();
        int i;
        logic [3:0] ph, pv;
        logic pb;
        for (i = 0; i < 300 && vcount !== 4'd2; i++) tick();
        run = 1'b0;
        ph = hcount; pv = vcount; pb = busy;
        for (i = 0; i < 300; i++) begin
            ph = hcount; pv = vcount; pb = busy;
            tick();
            if (busy !== 1'b1) break;
        end
        tests_run++; if (busy !== 1'b0 || m_busy !== 1'b0) begin tests_failed++;
            $display("FAIL stop_busy: got busy=%0d expected 0 at model frame end (model busy=%0d)", busy, m_busy); end
        tests_run++; if (ph !== 4'd14 || pv !== 4'd7 || pb !== 1'b1) begin tests_failed++;
            $display("FAIL stop_complete: busy fell after (%0d,%0d) busy=%0d expected (14,7) 1", ph, pv, pb); end
        tests_run++; if (hcount !== 4'd14 || vcount !== 4'd7 || ls !== 1'b0 || fs !== 1'b0) begin tests_failed++;
            $display("FAIL stop_idle_pos: got (%0d,%0d) ls=%0d fs=%0d expected (14,7) 0 0", hcount, vcount, ls, fs); end
        repeat (10) tick();
        tests_run++; if (hcount !== 4'd14 || busy !== 1'b0 || de !== 1'b0 || hsync !== 1'b1) begin tests_failed++;
            $display("FAIL stop_hold: got h=%0d busy=%0d de=%0d hs=%0d", hcount, busy, de, hsync); end
        run = 1'b1;
        tick();
        tests_run++; if (fs !== 1'b1 || ls !== 1'b1 || hcount !== 4'd0 || vcount !== 4'd0 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL stop_restart: got fs=%0d ls=%0d (%0d,%0d) busy=%0d expected 1 1 (0,0) 1",
                                     fs, ls, hcount, vcount, busy); end
    endtask

    task automatic test_back_to_back();
        int i;
        for (i = 0; i < 300 && vcount !== 4'd3; i++) tick();
        run = 1'b0;
        repeat (5) tick();
        run = 1'b1;
        for (i = 0; i < 200; i++) begin
            tick();
            tests_run++; if (busy !== 1'b1) begin tests_failed++;
                $display("FAIL seamless_busy: got busy=%0d expected 1", busy); end
            if (fs === 1'b1) break;
        end
        tests_run++; if (fs !== 1'b1 || hcount !== 4'd0 || vcount !== 4'd0) begin tests_failed++;
            $display("FAIL seamless_wrap: got fs=%0d (%0d,%0d) expected 1 (0,0)", fs, hcount, vcount); end
    endtask

    task automatic test_async_reset();
        repeat (20) tick();
        #3;
        reset_n = 1'b0;
        #1;
        tests_run++; if (hcount !== 4'd14 || vcount !== 4'd7 || busy !== 1'b0 || hsync !== 1'b1 || de !== 1'b0) begin
            tests_failed++; $display("FAIL async_reset: got (%0d,%0d) busy=%0d hs=%0d de=%0d expected (14,7) 0 1 0",
                                     hcount, vcount, busy, hsync, de); end
        tests_run++; if (hc_b !== 10'd383 || vc_b !== 10'd261 || busy_b !== 1'b0) begin tests_failed++;
            $display("FAIL async_reset_big: got (%0d,%0d) busy=%0d expected (383,261) 0", hc_b, vc_b, busy_b); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        tick();
        tests_run++; if (fs !== 1'b1 || hcount !== 4'd0 || busy !== 1'b1) begin tests_failed++;
            $display("FAIL reset_restart: got fs=%0d h=%0d busy=%0d expected 1 0 1", fs, hcount, busy); end
    endtask

    initial begin
        test_reset();
        test_big_line();
        test_frame();
        test_ce_div();
        test_polarity();
        test_stop();
        test_back_to_back();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
